// File: rtl/spinner_multi.sv
// Multi-channel spinner position counters driven by digital plus/minus levels
// stepped on strobe rises and by toggle-tagged analog deltas. Optional macro: SPINNER_ACCEL_EN.
module spinner_multi #(
    parameter int NCH          = 2,
    parameter int W            = 8,
    parameter int STEP_SLOW    = 1,
    parameter int STEP_FAST    = 4,
    parameter int ACCEL_FRAMES = 8,
    parameter int SPIN_SHIFT   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               strobe,
    input  logic [NCH-1:0]     minus,
    input  logic [NCH-1:0]     plus,
    input  logic [9*NCH-1:0]   spin_in,
    input  logic [NCH-1:0]     clamp,
    output logic [W*NCH-1:0]   spin_out,
    output logic [NCH-1:0]     moved
);

    localparam int SW = W + 9;
    localparam logic signed [SW-1:0] POS_MAX = {9'b0, {W{1'b1}}};

    generate
        if (NCH < 1 || NCH > 8 || W < 4 || W > 16 || STEP_FAST < STEP_SLOW ||
            STEP_FAST >= (1 << (W - 1)) || ACCEL_FRAMES < 1 || ACCEL_FRAMES > 255 ||
            SPIN_SHIFT < 0 || SPIN_SHIFT > 7) begin : g_bad_cfg
            $error("spinner_multi: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    logic                 strobe_q;
    logic                 step_evt;
    logic [NCH-1:0]       tag_q;
    logic [W-1:0]         pos_q     [NCH];
    logic [W-1:0]         pos_d     [NCH];
    dir_t                 dir_now   [NCH];
    logic signed [SW-1:0] step      [NCH];
    logic signed [SW-1:0] delta_dig [NCH];
    logic signed [SW-1:0] ana_ext   [NCH];
    logic signed [SW-1:0] delta_ana [NCH];
    logic signed [SW-1:0] sum       [NCH];
`ifdef SPINNER_ACCEL_EN
    logic [7:0]           hold_q    [NCH];
    logic [7:0]           hold_d    [NCH];
    dir_t                 dir_q     [NCH];
    dir_t                 dir_d     [NCH];
`endif

    assign step_evt = strobe & ~strobe_q;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            dir_now[c] = DIR_NONE;
            if (plus[c] && !minus[c]) begin
                dir_now[c] = DIR_UP;
            end else if (minus[c] && !plus[c]) begin
                dir_now[c] = DIR_DOWN;
            end

            step[c] = SW'(STEP_SLOW);
`ifdef SPINNER_ACCEL_EN
            hold_d[c] = hold_q[c];
            dir_d[c]  = dir_q[c];
            if (step_evt) begin
                dir_d[c] = dir_now[c];
                if (dir_now[c] == DIR_NONE) begin
                    hold_d[c] = 8'd0;
                end else if (dir_now[c] == dir_q[c]) begin
                    // Counter never exceeds ACCEL_FRAMES, so equality is the saturation test
                    hold_d[c] = (hold_q[c] == 8'(ACCEL_FRAMES)) ? hold_q[c] : hold_q[c] + 8'd1;
                end else begin
                    hold_d[c] = 8'd1;
                end
            end
            if (hold_d[c] == 8'(ACCEL_FRAMES)) begin
                step[c] = SW'(STEP_FAST);
            end
`endif

            delta_dig[c] = '0;
            if (step_evt) begin
                if (dir_now[c] == DIR_UP) begin
                    delta_dig[c] = step[c];
                end else if (dir_now[c] == DIR_DOWN) begin
                    delta_dig[c] = -step[c];
                end
            end

            ana_ext[c]   = {{(SW-8){spin_in[9*c+7]}}, spin_in[9*c +: 8]};
            delta_ana[c] = '0;
            if (spin_in[9*c+8] != tag_q[c]) begin
                delta_ana[c] = ana_ext[c] >>> SPIN_SHIFT;
            end

            // Both contributions land in one signed sum so a single update is applied
            sum[c] = $signed({9'b0, pos_q[c]}) + delta_dig[c] + delta_ana[c];
            if (clamp[c] && sum[c][SW-1]) begin
                pos_d[c] = '0;
            end else if (clamp[c] && (sum[c] > POS_MAX)) begin
                pos_d[c] = '1;
            end else begin
                pos_d[c] = sum[c][W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q <= 1'b0;
            tag_q    <= '0;
            moved    <= '0;
            for (int c = 0; c < NCH; c++) begin
                pos_q[c]  <= '0;
`ifdef SPINNER_ACCEL_EN
                hold_q[c] <= 8'd0;
                dir_q[c]  <= DIR_NONE;
`endif
            end
        end else begin
            strobe_q <= strobe;
            for (int c = 0; c < NCH; c++) begin
                tag_q[c]  <= spin_in[9*c+8];
                pos_q[c]  <= pos_d[c];
                moved[c]  <= (pos_d[c] != pos_q[c]);
`ifdef SPINNER_ACCEL_EN
                hold_q[c] <= hold_d[c];
                dir_q[c]  <= dir_d[c];
`endif
            end
        end
    end

    always_comb begin
        spin_out = '0;
        for (int c = 0; c < NCH; c++) begin
            spin_out[c*W +: W] = pos_q[c];
        end
    end

endmodule
